// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master port between two burst requesters.
// Grants are registered; wrt/cmd forwarding and done routing are combinational.
module spi_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        wrt0,
    input  logic        wrt1,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  rd_data0,
    output logic [7:0]  rd_data1,
    output logic        m_wrt,
    output logic [15:0] m_cmd,
    input  logic        m_done,
    input  logic [7:0]  m_rd_data,
    output logic        tmo
);

    typedef enum logic [1:0] {StIdle, StOwned, StBusy} state_e;

    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;

    logic        own_req;
    logic        own_wrt;
    logic [15:0] own_cmd;
    logic        cnt_hit;

    assign own_req = owner_q ? req1 : req0;
    assign own_wrt = owner_q ? wrt1 : wrt0;
    assign own_cmd = owner_q ? cmd1 : cmd0;
    assign cnt_hit = (cnt_q >= TmoLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                // On a tie the port that was not served last wins.
                if (req0 && req1) begin
                    owner_d = ~last_q;
                    state_d = StOwned;
                    cnt_d   = 16'h0;
                end else if (req0 || req1) begin
                    owner_d = req1;
                    state_d = StOwned;
                    cnt_d   = 16'h0;
                end
            end
            StOwned: begin
                if (own_wrt) begin
                    state_d = StBusy;
                    cnt_d   = 16'h0;
                end else if (!own_req || cnt_hit) begin
                    state_d = StIdle;
                    last_d  = owner_q;
                end else if (cnt_q != 16'hffff) begin
                    cnt_d = cnt_q + 16'h1;
                end
            end
            StBusy: begin
                if (m_done) begin
                    if (own_wrt) begin
                        cnt_d = 16'h0;
                    end else if (own_req) begin
                        state_d = StOwned;
                        cnt_d   = 16'h0;
                    end else begin
                        state_d = StIdle;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        logic fwd;
        logic fin;
        logic tmo_hit;
        fwd     = 1'b0;
        fin     = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            StOwned: begin
                fwd     = own_wrt;
                tmo_hit = !own_wrt && own_req && cnt_hit;
            end
            StBusy: begin
                fin = m_done;
                fwd = m_done && own_wrt;
            end
            default: ;
        endcase
        gnt0     = (state_q != StIdle) && !owner_q;
        gnt1     = (state_q != StIdle) && owner_q;
        m_wrt    = fwd && !rst;
        m_cmd    = (fwd && !rst) ? own_cmd : 16'h0;
        done0    = fin && !rst && !owner_q;
        done1    = fin && !rst && owner_q;
        tmo      = tmo_hit && !rst;
        rd_data0 = m_rd_data;
        rd_data1 = m_rd_data;
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Randomised bench for spi_arbiter: a transaction-level model predicts grants and
// master-side events; a monitor compares them against the DUT each cycle.
module tb_spi_arbiter;

    localparam int unsigned T = 16;
    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        rst, req0, req1, wrt0, wrt1, m_done;
    logic [15:0] cmd0, cmd1;
    logic [7:0]  m_rd_data;
    logic        gnt0, gnt1, done0, done1, m_wrt, tmo;
    logic [15:0] m_cmd;
    logic [7:0]  rd_data0, rd_data1;

    always #5 clk = ~clk;

    spi_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wrt0(wrt0), .wrt1(wrt1),
        .cmd0(cmd0), .cmd1(cmd1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .m_wrt(m_wrt), .m_cmd(m_cmd), .m_done(m_done), .m_rd_data(m_rd_data),
        .tmo(tmo)
    );

    typedef struct {
        int          cyc;
        logic        mw;
        logic [15:0] cmd;
        logic [1:0]  dn;
        logic        tmo;
        logic [7:0]  rd;
    } ev_t;

    ev_t        evq[$];
    logic [1:0] gq[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference: who holds the bus (-1 = nobody), whether a transfer is in flight,
    // who was served last, and how long the holder has sat without traffic.
    int m_owner = -1;
    bit m_busy  = 1'b0;
    int m_last  = 1;
    int m_idle  = 0;

    task automatic model_step(input bit rs, input bit rq0, input bit rq1, input bit w0,
                              input bit w1, input logic [15:0] c0, input logic [15:0] c1,
                              input bit md, input logic [7:0] rd, output bit fwd);
        ev_t e;
        bit  rq[2];
        bit  w[2];
        int  o;
        rq[0] = rq0; rq[1] = rq1; w[0] = w0; w[1] = w1;
        o = m_owner;
        gq.push_back((o < 0) ? 2'b00 : (o == 0 ? 2'b01 : 2'b10));
        e = '{cyc: cyc, mw: 1'b0, cmd: 16'h0, dn: 2'b00, tmo: 1'b0, rd: rd};
        fwd = 1'b0;
        if (rs) begin
            m_owner = -1; m_busy = 1'b0; m_last = 1; m_idle = 0;
        end else if (o < 0) begin
            if (rq[0] && rq[1]) m_owner = 1 - m_last;
            else if (rq[0])     m_owner = 0;
            else if (rq[1])     m_owner = 1;
            m_idle = 0;
        end else if (!m_busy) begin
            if (w[o]) begin
                fwd = 1'b1; m_busy = 1'b1; m_idle = 0;
            end else if (!rq[o]) begin
                m_last = o; m_owner = -1;
            end else if (m_idle == int'(T) - 1) begin
                e.tmo = 1'b1; m_last = o; m_owner = -1;
            end else begin
                m_idle++;
            end
        end else if (md) begin
            e.dn[o] = 1'b1;
            if (w[o]) begin
                fwd = 1'b1; m_idle = 0;
            end else if (rq[o]) begin
                m_busy = 1'b0; m_idle = 0;
            end else begin
                m_busy = 1'b0; m_last = o; m_owner = -1;
            end
        end
        if (fwd) begin
            e.mw  = 1'b1;
            e.cmd = (o == 1) ? c1 : c0;
        end
        if (e.mw || e.dn != 2'b00 || e.tmo) evq.push_back(e);
    endtask

    // Monitor
    initial begin
        ev_t        e;
        logic [1:0] g;
        forever begin
            @(negedge clk);
            if (gq.size() > 0) begin
                g = gq.pop_front();
                total++;
                if ({gnt1, gnt0} !== g) begin
                    bad++;
                    $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, {gnt1, gnt0}, g);
                end
            end
            if (!m_wrt) begin
                total++;
                if (m_cmd !== 16'h0) begin
                    bad++;
                    $display("FAIL m_cmd_idle cyc=%0d got=%h exp=0000", cyc, m_cmd);
                end
            end
            if (m_wrt || done0 || done1 || tmo) begin
                total++;
                if (evq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event cyc=%0d got wrt=%b cmd=%h done=%b%b tmo=%b exp none",
                             cyc, m_wrt, m_cmd, done1, done0, tmo);
                end else begin
                    e = evq.pop_front();
                    if (e.cyc != cyc || m_wrt !== e.mw || (e.mw && m_cmd !== e.cmd) ||
                        {done1, done0} !== e.dn || tmo !== e.tmo ||
                        (e.dn != 2'b00 && (rd_data0 !== e.rd || rd_data1 !== e.rd))) begin
                        bad++;
                        $display("FAIL event cyc=%0d got wrt=%b cmd=%h done=%b%b tmo=%b rd=%h/%h exp cyc=%0d wrt=%b cmd=%h done=%b tmo=%b rd=%h",
                                 cyc, m_wrt, m_cmd, done1, done0, tmo, rd_data0, rd_data1,
                                 e.cyc, e.mw, e.cmd, e.dn, e.tmo, e.rd);
                    end
                end
            end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
                e = evq.pop_front();
                total++;
                bad++;
                $display("FAIL missing_event cyc=%0d got none exp wrt=%b cmd=%h done=%b tmo=%b",
                         cyc, e.mw, e.cmd, e.dn, e.tmo);
            end
        end
    end

    // Stimulus plus a simple spi_master responder driven from predicted forwards
    initial begin
        bit r0, r1, fwd;
        int timer, wp, fp;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; wrt0 = 1'b0; wrt1 = 1'b0;
        cmd0 = 16'h0; cmd1 = 16'h0; m_done = 1'b0; m_rd_data = 8'h0;
        r0 = 1'b1; r1 = 1'b1; timer = 0;
        for (int i = 0; i < NCYC + 20; i++) begin
            @(posedge clk);
            #1;
            cyc = i;
            case (i / 600)
                0:       begin wp = 30; fp = 8; end
                1:       begin wp = 0;  fp = 3; end
                2:       begin wp = 90; fp = 4; end
                3:       begin wp = 30; fp = 10; end
                default: begin wp = 60; fp = 6; end
            endcase
            rst = (i < 3) || (i >= 1500 && i < 1502);
            if (i < 3) begin
                r0 = 1'b1; r1 = 1'b1;
            end else begin
                if ($urandom_range(99) < fp) r0 = ~r0;
                if ($urandom_range(99) < fp) r1 = ~r1;
            end
            if (i >= NCYC) begin
                r0 = 1'b0; r1 = 1'b0; wp = 0;
            end
            m_done = 1'b0;
            if (rst) begin
                timer = 0;
            end else if (timer > 0) begin
                timer--;
                m_done = (timer == 0);
            end
            req0 = r0; req1 = r1;
            wrt0 = ($urandom_range(99) < wp);
            wrt1 = ($urandom_range(99) < wp);
            cmd0 = 16'($urandom);
            cmd1 = 16'($urandom);
            m_rd_data = 8'($urandom);
            model_step(rst, req0, req1, wrt0, wrt1, cmd0, cmd1, m_done, m_rd_data, fwd);
            if (fwd) timer = $urandom_range(1, 6);
        end
        @(negedge clk);
        #1;
        total++;
        if (evq.size() != 0) begin
            bad++;
            $display("FAIL leftover_events got=%0d exp=0", evq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
